// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: opcode encodings, stack
// bounds, the register-file SP reset value and the bound-check helpers.
package stack_ctrl_pkg;

    // Register-file SP comes out of reset pointing at the empty-stack slot.
    localparam logic [31:0] RF_SP_RESET       = 32'd2047;
    localparam logic [31:0] SP_TOP_DEFAULT    = RF_SP_RESET;
    localparam logic [31:0] SP_BOTTOM_DEFAULT = 32'd0;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_HI,
        ST_WR_LO,
        ST_RD_A,
        ST_RD_B,
        ST_RD_C
    } state_e;

    // A push needs one free slot at SP. SP one below the bottom is what a
    // decrement past the bottom wraps to, so it is rejected explicitly.
    function automatic logic push_overflow(input logic [31:0] sp,
                                           input logic [31:0] bottom);
        return (sp < bottom) || (sp == bottom - 32'd1);
    endfunction

    // A call needs two free slots: SP and SP-1.
    function automatic logic call_overflow(input logic [31:0] sp,
                                           input logic [31:0] bottom);
        return (sp < bottom + 32'd1) || (sp == bottom - 32'd1);
    endfunction

    // A pop needs one occupied slot above SP.
    function automatic logic pop_underflow(input logic [31:0] sp,
                                           input logic [31:0] top);
        return sp >= top;
    endfunction

    // A return needs two occupied slots above SP.
    function automatic logic ret_underflow(input logic [31:0] sp,
                                           input logic [31:0] top);
        return sp > top - 32'd2;
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Stack controller: sequences PUSH/POP/CALL/RET onto a 16-bit data memory,
// updates SP and PC through register-file write ports, and stalls the
// requester while an operation is in flight.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a request; errors are answered from here
// ST_WR_HI | CALL: high half of the return address being written at SP
// ST_WR_LO | PUSH word / CALL low half written, SP write and done issued
// ST_RD_A  | POP/RET: read of SP+1 issued
// ST_RD_B  | RET: read of SP+2 issued, low half arriving on mem_rdata
// ST_RD_C  | POP/RET: last read word arriving, result captured on exit
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter logic [31:0] SP_TOP    = SP_TOP_DEFAULT,
    parameter logic [31:0] SP_BOTTOM = SP_BOTTOM_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] sp_in,
    input  logic [15:0] push_data,
    input  logic [31:0] pc_data,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        sp_write,
    output logic [31:0] write_sp_data,
    output logic        pc_write,
    output logic [31:0] write_pc_data,
    output logic        pop_valid,
    output logic [15:0] pop_data,
    output logic        done,
    output logic        stack_err
);

    state_e      state;
    logic [31:0] sp_q;
    logic [15:0] pc_lo_q;
    logic [15:0] ret_lo_q;
    logic        is_ret_q;

    // Sequencer: every output is computed for the state being entered, so
    // all of them are registered and change only on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            sp_q          <= '0;
            pc_lo_q       <= '0;
            ret_lo_q      <= '0;
            is_ret_q      <= 1'b0;
            busy          <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
            sp_write      <= 1'b0;
            write_sp_data <= '0;
            pc_write      <= 1'b0;
            write_pc_data <= '0;
            pop_valid     <= 1'b0;
            pop_data      <= '0;
            done          <= 1'b0;
            stack_err     <= 1'b0;
        end else begin
            // Strobes default low; data outputs keep their last value.
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            sp_write  <= 1'b0;
            pc_write  <= 1'b0;
            pop_valid <= 1'b0;
            done      <= 1'b0;
            stack_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (op_valid) begin
                        sp_q    <= sp_in;
                        pc_lo_q <= pc_data[15:0];
                        case (op_code)
                            OP_PUSH: begin
                                if (push_overflow(sp_in, SP_BOTTOM)) begin
                                    done      <= 1'b1;
                                    stack_err <= 1'b1;
                                end else begin
                                    state         <= ST_WR_LO;
                                    busy          <= 1'b1;
                                    mem_we        <= 1'b1;
                                    mem_addr      <= sp_in;
                                    mem_wdata     <= push_data;
                                    sp_write      <= 1'b1;
                                    write_sp_data <= sp_in - 32'd1;
                                    done          <= 1'b1;
                                end
                            end
                            OP_CALL: begin
                                if (call_overflow(sp_in, SP_BOTTOM)) begin
                                    done      <= 1'b1;
                                    stack_err <= 1'b1;
                                end else begin
                                    state     <= ST_WR_HI;
                                    busy      <= 1'b1;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= sp_in;
                                    mem_wdata <= pc_data[31:16];
                                end
                            end
                            OP_POP: begin
                                if (pop_underflow(sp_in, SP_TOP)) begin
                                    done      <= 1'b1;
                                    stack_err <= 1'b1;
                                end else begin
                                    state    <= ST_RD_A;
                                    busy     <= 1'b1;
                                    mem_re   <= 1'b1;
                                    mem_addr <= sp_in + 32'd1;
                                    is_ret_q <= 1'b0;
                                end
                            end
                            OP_RET: begin
                                if (ret_underflow(sp_in, SP_TOP)) begin
                                    done      <= 1'b1;
                                    stack_err <= 1'b1;
                                end else begin
                                    state    <= ST_RD_A;
                                    busy     <= 1'b1;
                                    mem_re   <= 1'b1;
                                    mem_addr <= sp_in + 32'd1;
                                    is_ret_q <= 1'b1;
                                end
                            end
                            default: begin
                                // NONE and reserved codes are dropped silently.
                            end
                        endcase
                    end
                end

                ST_WR_HI: begin
                    state         <= ST_WR_LO;
                    busy          <= 1'b1;
                    mem_we        <= 1'b1;
                    mem_addr      <= sp_q - 32'd1;
                    mem_wdata     <= pc_lo_q;
                    sp_write      <= 1'b1;
                    write_sp_data <= sp_q - 32'd2;
                    done          <= 1'b1;
                end

                ST_WR_LO: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                ST_RD_A: begin
                    busy <= 1'b1;
                    if (is_ret_q) begin
                        state    <= ST_RD_B;
                        mem_re   <= 1'b1;
                        mem_addr <= sp_q + 32'd2;
                    end else begin
                        state <= ST_RD_C;
                    end
                end

                ST_RD_B: begin
                    // Low half of the return address is on the bus now.
                    state    <= ST_RD_C;
                    busy     <= 1'b1;
                    ret_lo_q <= mem_rdata;
                end

                ST_RD_C: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    sp_write <= 1'b1;
                    done     <= 1'b1;
                    if (is_ret_q) begin
                        pc_write      <= 1'b1;
                        write_pc_data <= {mem_rdata, ret_lo_q};
                        write_sp_data <= sp_q + 32'd2;
                    end else begin
                        pop_valid     <= 1'b1;
                        pop_data      <= mem_rdata;
                        write_sp_data <= sp_q + 32'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a behavioural stack model plans the expected output
// trace of every request cycle by cycle; one negedge process compares the DUT
// against that trace, and scenario checks pin the model with literal values.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    localparam logic [31:0] TOP = 32'd2047;
    localparam logic [31:0] BOT = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] sp_in = '0;
    logic [15:0] push_data = '0;
    logic [31:0] pc_data = '0;
    logic [15:0] mem_rdata = '0;
    logic        busy, mem_we, mem_re, sp_write, pc_write, pop_valid, done, stack_err;
    logic [31:0] mem_addr, write_sp_data, write_pc_data;
    logic [15:0] mem_wdata, pop_data;

    always #5 clk = ~clk;

    stack_ctrl #(.SP_TOP(TOP), .SP_BOTTOM(BOT)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .sp_in(sp_in), .push_data(push_data), .pc_data(pc_data),
        .mem_rdata(mem_rdata), .busy(busy), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .sp_write(sp_write), .write_sp_data(write_sp_data),
        .pc_write(pc_write), .write_pc_data(write_pc_data),
        .pop_valid(pop_valid), .pop_data(pop_data), .done(done),
        .stack_err(stack_err)
    );

    // Data memory seen by the DUT: synchronous read, data one cycle after mem_re.
    logic [15:0] mem [int unsigned];
    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0;
    endfunction
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_rd(mem_addr);
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask
    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          rst_chk;
        bit          busy, we, re, spw, pcw, pv, done, err;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [31:0] wsp, wpc;
        logic [15:0] pdata;
    } exp_t;

    exp_t        exp_tab [int];
    logic [15:0] mref [int unsigned];
    logic [31:0] msp;

    function automatic logic [15:0] mref_rd(input logic [31:0] a);
        if (mref.exists(a)) return mref[a];
        return 16'h0;
    endfunction

    // Fill the expected trace for a request accepted at edge 'a' (outputs
    // visible in cycle a onward) and advance the model stack.
    task automatic plan(input logic [2:0] op, input logic [31:0] sp,
                        input logic [15:0] pd, input logic [31:0] pc, input int a);
        exp_t e0, e1, e2, e3;
        e0 = '{default: '0}; e1 = '{default: '0};
        e2 = '{default: '0}; e3 = '{default: '0};
        msp = sp;
        case (op)
            3'd1: begin
                if (sp < BOT || sp == BOT - 32'd1) begin
                    e0.done = 1; e0.err = 1; exp_tab[a] = e0;
                end else begin
                    e0.busy = 1; e0.we = 1; e0.addr = sp; e0.wdata = pd;
                    e0.spw = 1; e0.wsp = sp - 32'd1; e0.done = 1;
                    exp_tab[a] = e0;
                    mref[sp] = pd;
                    msp = sp - 32'd1;
                end
            end
            3'd3: begin
                if (sp < BOT + 32'd1 || sp == BOT - 32'd1) begin
                    e0.done = 1; e0.err = 1; exp_tab[a] = e0;
                end else begin
                    e0.busy = 1; e0.we = 1; e0.addr = sp; e0.wdata = pc[31:16];
                    e1.busy = 1; e1.we = 1; e1.addr = sp - 32'd1; e1.wdata = pc[15:0];
                    e1.spw = 1; e1.wsp = sp - 32'd2; e1.done = 1;
                    exp_tab[a] = e0; exp_tab[a+1] = e1;
                    mref[sp] = pc[31:16];
                    mref[sp - 32'd1] = pc[15:0];
                    msp = sp - 32'd2;
                end
            end
            3'd2: begin
                if (sp >= TOP) begin
                    e0.done = 1; e0.err = 1; exp_tab[a] = e0;
                end else begin
                    e0.busy = 1; e0.re = 1; e0.addr = sp + 32'd1;
                    e1.busy = 1;
                    e2.pv = 1; e2.pdata = mref_rd(sp + 32'd1);
                    e2.spw = 1; e2.wsp = sp + 32'd1; e2.done = 1;
                    exp_tab[a] = e0; exp_tab[a+1] = e1; exp_tab[a+2] = e2;
                    msp = sp + 32'd1;
                end
            end
            3'd4: begin
                if (sp > TOP - 32'd2) begin
                    e0.done = 1; e0.err = 1; exp_tab[a] = e0;
                end else begin
                    e0.busy = 1; e0.re = 1; e0.addr = sp + 32'd1;
                    e1.busy = 1; e1.re = 1; e1.addr = sp + 32'd2;
                    e2.busy = 1;
                    e3.pcw = 1; e3.wpc = {mref_rd(sp + 32'd2), mref_rd(sp + 32'd1)};
                    e3.spw = 1; e3.wsp = sp + 32'd2; e3.done = 1;
                    exp_tab[a] = e0; exp_tab[a+1] = e1;
                    exp_tab[a+2] = e2; exp_tab[a+3] = e3;
                    msp = sp + 32'd2;
                end
            end
            default: begin
            end
        endcase
    endtask

    // ---------------- per-cycle compare and monitors ----------------
    int          n_busy = 0, n_done = 0, n_err = 0, n_spw = 0, n_re = 0, n_pcw = 0;
    int          last_done_cyc = 0;
    logic [31:0] last_wsp = '0, last_pc = '0;
    logic [15:0] last_pop = '0;

    always @(negedge clk) begin : cmp
        exp_t e;
        if (cyc > 0) begin
            e = '{default: '0};
            if (exp_tab.exists(cyc)) e = exp_tab[cyc];
            if (e.rst_chk) begin
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_mem_we", mem_we, 1'b0);
                chk1("rst_mem_re", mem_re, 1'b0);
                chk1("rst_sp_write", sp_write, 1'b0);
                chk1("rst_pc_write", pc_write, 1'b0);
                chk1("rst_pop_valid", pop_valid, 1'b0);
                chk1("rst_done", done, 1'b0);
                chk1("rst_stack_err", stack_err, 1'b0);
                chk32("rst_mem_addr", mem_addr, 32'h0);
                chk16("rst_mem_wdata", mem_wdata, 16'h0);
                chk32("rst_write_sp_data", write_sp_data, 32'h0);
                chk32("rst_write_pc_data", write_pc_data, 32'h0);
                chk16("rst_pop_data", pop_data, 16'h0);
            end else begin
                chk1("busy", busy, e.busy);
                chk1("mem_we", mem_we, e.we);
                chk1("mem_re", mem_re, e.re);
                chk1("sp_write", sp_write, e.spw);
                chk1("pc_write", pc_write, e.pcw);
                chk1("pop_valid", pop_valid, e.pv);
                chk1("done", done, e.done);
                chk1("stack_err", stack_err, e.err);
                if (e.we || e.re) chk32("mem_addr", mem_addr, e.addr);
                if (e.we)  chk16("mem_wdata", mem_wdata, e.wdata);
                if (e.spw) chk32("write_sp_data", write_sp_data, e.wsp);
                if (e.pcw) chk32("write_pc_data", write_pc_data, e.wpc);
                if (e.pv)  chk16("pop_data", pop_data, e.pdata);
            end
            if (busy) n_busy++;
            if (done) begin n_done++; last_done_cyc = cyc; end
            if (stack_err) n_err++;
            if (sp_write) begin n_spw++; last_wsp = write_sp_data; end
            if (mem_re) n_re++;
            if (pc_write) begin n_pcw++; last_pc = write_pc_data; end
            if (pop_valid) last_pop = pop_data;
        end
    end

    // ---------------- driver ----------------
    // Waits for busy low, presents the request for one edge and plans it.
    // With hold set, keeps a PUSH request asserted for as long as busy is high.
    task automatic do_op(input logic [2:0] op, input logic [31:0] sp,
                         input logic [15:0] pd, input logic [31:0] pc,
                         input bit hold, output int a);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL busy_wait cycle %0d: busy still %b after %0d cycles, want 0", cyc, busy, n);
        end
        op_valid  = 1'b1;
        op_code   = op;
        sp_in     = sp;
        push_data = pd;
        pc_data   = pc;
        a = cyc + 1;
        plan(op, sp, pd, pc, a);
        @(negedge clk);
        if (hold) begin
            op_code = OP_PUSH;
            n = 0;
            while (busy === 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        op_valid = 1'b0;
        op_code  = 3'd0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: bench still running at cycle %0d, want finished", cyc);
        $fatal(1, "timeout");
    end

    logic [31:0] bnd [0:7];

    initial begin : main
        int a, b0, d0, e0, s0, r0, p0;
        exp_t er;
        bnd[0] = 32'd0;    bnd[1] = 32'd1;    bnd[2] = 32'd2;    bnd[3] = 32'hFFFF_FFFF;
        bnd[4] = 32'd2045; bnd[5] = 32'd2046; bnd[6] = 32'd2047; bnd[7] = 32'd2048;

        // Reset for three edges.
        er = '{default: '0};
        er.rst_chk = 1;
        for (int c = 1; c <= 3; c++) exp_tab[c] = er;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_busy", busy, 1'b0);
        chk32("reset_write_sp_data", write_sp_data, 32'h0);
        chk16("reset_pop_data", pop_data, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        msp = RF_SP_RESET;

        // PUSH 0xBEEF at SP 2047.
        b0 = n_busy;
        do_op(3'd1, 32'd2047, 16'hBEEF, 32'h0, 0, a);
        settle();
        chk16("push_mem2047", mem_rd(32'd2047), 16'hBEEF);
        chk32("push_new_sp", last_wsp, 32'd2046);
        chk32("push_busy_cycles", 32'(n_busy - b0), 32'd1);

        // POP it back.
        do_op(3'd2, 32'd2046, 16'h0, 32'h0, 0, a);
        settle();
        chk16("pop_data_val", last_pop, 16'hBEEF);
        chk32("pop_new_sp", last_wsp, 32'd2047);
        chk32("pop_done_lag", 32'(last_done_cyc - a), 32'd2);

        // CALL then RET.
        do_op(3'd3, 32'd2047, 16'h0, 32'h0001_0020, 0, a);
        settle();
        chk16("call_mem2047", mem_rd(32'd2047), 16'h0001);
        chk16("call_mem2046", mem_rd(32'd2046), 16'h0020);
        do_op(3'd4, 32'd2045, 16'h0, 32'h0, 0, a);
        settle();
        chk32("ret_pc", last_pc, 32'h0001_0020);
        chk32("ret_new_sp", last_wsp, 32'd2047);

        // Underflows.
        e0 = n_err; s0 = n_spw; r0 = n_re;
        do_op(3'd2, 32'd2047, 16'h0, 32'h0, 0, a);
        do_op(3'd4, 32'd2046, 16'h0, 32'h0, 0, a);
        settle();
        chk32("underflow_errs", 32'(n_err - e0), 32'd2);
        chk32("underflow_sp_writes", 32'(n_spw - s0), 32'd0);
        chk32("underflow_reads", 32'(n_re - r0), 32'd0);

        // Request held while busy is ignored; exactly one done.
        do_op(3'd3, 32'd2047, 16'h0, 32'h1234_5678, 0, a);
        settle();
        d0 = n_done;
        do_op(3'd4, 32'd2045, 16'h0, 32'h0, 1, a);
        settle();
        chk32("held_req_done_count", 32'(n_done - d0), 32'd1);
        chk32("held_req_ret_pc", last_pc, 32'h1234_5678);

        // Reset during RD_B of a RET.
        do_op(3'd3, 32'd2047, 16'h0, 32'hCAFE_1234, 0, a);
        settle();
        p0 = n_pcw; s0 = n_spw;
        do_op(3'd4, 32'd2045, 16'h0, 32'h0, 0, a);
        @(negedge clk);
        rst = 1'b0;
        exp_tab.delete(a + 2);
        exp_tab.delete(a + 3);
        exp_tab[a + 2] = er;
        msp = 32'd2045;
        @(negedge clk);
        rst = 1'b1;
        settle();
        chk32("midreset_pc_writes", 32'(n_pcw - p0), 32'd0);
        chk32("midreset_sp_writes", 32'(n_spw - s0), 32'd0);
        chk1("midreset_busy", busy, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [2:0] op;
            logic [31:0] sp;
            r = $urandom_range(0, 11);
            if (r == 0)      op = 3'd0;
            else if (r == 1) op = 3'($urandom_range(5, 7));
            else             op = 3'(1 + (r % 4));
            if ($urandom_range(0, 9) < 7)      sp = msp;
            else if ($urandom_range(0, 4) > 0) sp = bnd[$urandom_range(0, 7)];
            else                               sp = $urandom;
            do_op(op, sp, 16'($urandom), $urandom, 0, a);
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
